fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage and IF/ID pipeline register for the 16-bit RISC core. It holds the PC and runs a single-outstanding request/acknowledge handshake to instruction memory. It buffers one instruction across decode stalls and applies branch redirects and flushes from EX. Its `if_id_instr[15:12]` output is the 4-bit opcode that drives the main control decoder directly downstream.

## Interface
- `RESET_PC`, 16'h0000, word address fetched first after reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `imem_req` out 1: fetch request to instruction memory.
- `imem_addr` out 16: word address of the request; held stable while `imem_req`=1 until `imem_ack`.
- `imem_ack` in 1: `imem_rdata` valid this cycle; may assert in the same cycle as `imem_req`.
- `imem_rdata` in 16: instruction word.
- `stall` in 1: decode stall from the hazard unit; IF/ID holds its value.
- `branch_taken` in 1: redirect from EX (BEQ/BNE resolved).
- `branch_target` in 16: redirect word address.
- `if_id_valid` out 1: IF/ID holds a real instruction.
- `if_id_instr` out 16: instruction to decode; opcode is `[15:12]`.
- `if_id_pc` out 16: fetch address + 1 of that instruction.
- `bubble_cnt` out 16: present only with `FETCH_BUBBLE_CNT_EN`.

## Operation
- Bubble encoding: `if_id_valid`=0 and `if_id_instr`=16'h0000 (add $0,$0,$0, architecturally a NOP). Decode gates RegWrite and MemWrite with `if_id_valid`.
- Registers: `pc`, `state`, `skid_instr`/`skid_pc`, `redir_pc`, IF/ID.
- States:
  - IDLE: reset state; `imem_req`=0; next cycle goes to FETCH.
  - FETCH: `imem_req`=1, `imem_addr`=`pc`.
    - ack & !stall: IF/ID <= {1, rdata, pc+1}; `pc`<=`pc`+1; stay in FETCH.
    - ack & stall: skid <= {rdata, pc+1}; `pc`<=`pc`+1; go to HOLD.
    - no ack & !stall: IF/ID <= bubble.
    - no ack & stall: IF/ID holds.
  - HOLD: `imem_req`=0.
    - !stall: IF/ID <= skid (valid=1); go to FETCH.
    - stall: hold.
  - DROP: `imem_req`=1 at the old `pc` until ack.
    - On ack: discard data; `pc`<=`redir_pc`; go to FETCH.
    - IF/ID receives a bubble whenever !stall.
- Branch priority: `branch_taken` overrides `stall` and `ack`. IF/ID <= bubble, skid invalidated.
  - FETCH with ack same cycle: data discarded; `pc`<=`branch_target`; stay in FETCH.
  - FETCH without ack: `redir_pc`<=`branch_target`; go to DROP.
  - HOLD: `pc`<=`branch_target`; go to FETCH.
  - DROP: `redir_pc`<=`branch_target` (latest redirect wins); if ack that same cycle, go to FETCH at `branch_target`.
  - IDLE: `pc`<=`branch_target`.
- PC arithmetic is 16-bit modulo; 16'hFFFF+1 wraps to 16'h0000 (`if_id_pc`=16'h0000).

## Timing
- Reset (`rst_n`=0 at edge):
  - `state`=IDLE, `pc`=`RESET_PC`.
  - Outputs: `imem_req`=0, `imem_addr`=`RESET_PC`, `if_id_valid`=0, `if_id_instr`=0, `if_id_pc`=0, `bubble_cnt`=0.
  - Reset mid-request abandons the outstanding ack. After reset, memory must not ack without a new `imem_req`.
- First `imem_req` appears in the second cycle after `rst_n` rises.
- With zero-wait memory (ack same cycle), throughput is 1 instruction/cycle. An instruction is in IF/ID the cycle after its ack.
- Branch penalty with zero-wait memory: 1 bubble; target instruction is valid in IF/ID 2 cycles after the `branch_taken` cycle.
- `imem_req`/`imem_addr` are registered-state decodes with no combinational path from `stall` or `branch_taken`.

## Configuration
- `FETCH_BUBBLE_CNT_EN` defined:
  - `bubble_cnt` port exists.
  - 16-bit counter increments on every cycle where, after the edge, `if_id_valid`=0 and not in reset; saturates at 16'hFFFF.
  - Cleared by reset only.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset release, zero-wait memory returning `imem_rdata`=`{4'h0,addr[11:0]}` -> `imem_addr` 0,1,2,... on consecutive cycles; `if_id_instr`=16'h0000,16'h0001,... with `if_id_pc`=1,2,..., `if_id_valid`=1 every cycle.
- Memory acks 2 cycles after request, no stall -> `if_id_valid` pattern 0,0,1 repeating; `pc` advances once per ack.
- `stall`=1 for 3 cycles while an ack of 16'h5123 arrives -> state goes to HOLD with `imem_req`=0; IF/ID unchanged during stall; `if_id_instr`=16'h5123 the cycle after `stall` drops.
- `branch_taken` with target 16'h0040 while a request is pending, ack next cycle with 16'hFFFF -> 16'hFFFF never reaches IF/ID (`if_id_valid`=0); next request is at `imem_addr`=16'h0040.
- `branch_taken` and `stall` in the same cycle while in HOLD -> skid is dropped, `if_id_valid`=0, next `imem_addr`=`branch_target`.
- `RESET_PC`=16'hFFFF, zero-wait memory -> second fetch at 16'h0000, `if_id_pc`=16'h0000 for the first instruction. With `FETCH_BUBBLE_CNT_EN`, `bubble_cnt`=2 after the first valid instruction (reset-release cycle + IDLE→FETCH cycle).

Source files
------------

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction fetch stage and IF/ID pipeline register for the
//                16-bit RISC core. It holds the PC and runs a single-outstanding
//                req/ack handshake to instruction memory. A one-entry skid
//                buffer carries a fetched word across decode stalls. It also
//                applies branch redirects from EX, including redirects that
//                arrive while a request is still outstanding.
//                Optional feature macro: FETCH_BUBBLE_CNT_EN adds a saturating
//                16-bit count of bubble cycles on port bubble_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic        if_id_valid,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc
`ifdef FETCH_BUBBLE_CNT_EN
    ,
    output logic [15:0] bubble_cnt
`endif
);

    // FSM encoding
    localparam logic [1:0] C_IDLE  = 2'd0;  // post-reset, no request
    localparam logic [1:0] C_FETCH = 2'd1;  // request outstanding at pc
    localparam logic [1:0] C_HOLD  = 2'd2;  // fetched word parked in skid
    localparam logic [1:0] C_DROP  = 2'd3;  // wait out a request killed by a redirect

    // add $0,$0,$0 is architecturally a NOP, so a bubble is all zeros
    localparam logic [15:0] C_NOP_INSTR = 16'h0000;

    logic [1:0]  state_q,       state_d;
    logic [15:0] pc_q,          pc_d;
    logic [15:0] redir_pc_q,    redir_pc_d;
    logic [15:0] skid_instr_q,  skid_instr_d;
    logic [15:0] skid_pc_q,     skid_pc_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic [15:0] if_id_instr_q, if_id_instr_d;
    logic [15:0] if_id_pc_q,    if_id_pc_d;

    // 16-bit modulo increment; 16'hFFFF wraps to 16'h0000
    logic [15:0] pc_plus1;
    assign pc_plus1 = pc_q + 16'd1;

    // Memory-side outputs decode registered state only, so neither stall nor
    // branch_taken has a combinational path to the memory interface.
    assign imem_req    = (state_q == C_FETCH) || (state_q == C_DROP);
    assign imem_addr   = pc_q;

    assign if_id_valid = if_id_valid_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_pc    = if_id_pc_q;

    // Next-state logic: branch redirect has priority over stall and ack
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        redir_pc_d    = redir_pc_q;
        skid_instr_d  = skid_instr_q;
        skid_pc_d     = skid_pc_q;
        if_id_valid_d = if_id_valid_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc_d    = if_id_pc_q;

        case (state_q)
            C_IDLE: begin
                // Nothing has been fetched yet, so IF/ID keeps carrying a bubble
                if_id_valid_d = 1'b0;
                if_id_instr_d = C_NOP_INSTR;
                if_id_pc_d    = 16'h0000;
                state_d       = C_FETCH;
                if (branch_taken) begin
                    pc_d = branch_target;
                end
            end

            C_FETCH: begin
                if (branch_taken) begin
                    if_id_valid_d = 1'b0;
                    if_id_instr_d = C_NOP_INSTR;
                    if_id_pc_d    = 16'h0000;
                    if (imem_ack) begin
                        // Returning word is on the wrong path; refetch at target
                        pc_d = branch_target;
                    end else begin
                        // Request still in flight; it must complete before the
                        // target can be requested
                        redir_pc_d = branch_target;
                        state_d    = C_DROP;
                    end
                end else if (imem_ack) begin
                    pc_d = pc_plus1;
                    if (!stall) begin
                        if_id_valid_d = 1'b1;
                        if_id_instr_d = imem_rdata;
                        if_id_pc_d    = pc_plus1;
                    end else begin
                        // Decode is stalled; park the word in the skid buffer
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = pc_plus1;
                        state_d      = C_HOLD;
                    end
                end else if (!stall) begin
                    if_id_valid_d = 1'b0;
                    if_id_instr_d = C_NOP_INSTR;
                    if_id_pc_d    = 16'h0000;
                end
            end

            C_HOLD: begin
                if (branch_taken) begin
                    // Skid contents are wrong-path; leaving HOLD discards them
                    if_id_valid_d = 1'b0;
                    if_id_instr_d = C_NOP_INSTR;
                    if_id_pc_d    = 16'h0000;
                    pc_d          = branch_target;
                    state_d       = C_FETCH;
                end else if (!stall) begin
                    if_id_valid_d = 1'b1;
                    if_id_instr_d = skid_instr_q;
                    if_id_pc_d    = skid_pc_q;
                    state_d       = C_FETCH;
                end
            end

            C_DROP: begin
                if (branch_taken) begin
                    // Most recent redirect wins
                    if_id_valid_d = 1'b0;
                    if_id_instr_d = C_NOP_INSTR;
                    if_id_pc_d    = 16'h0000;
                    redir_pc_d    = branch_target;
                    if (imem_ack) begin
                        pc_d    = branch_target;
                        state_d = C_FETCH;
                    end
                end else begin
                    if (!stall) begin
                        if_id_valid_d = 1'b0;
                        if_id_instr_d = C_NOP_INSTR;
                        if_id_pc_d    = 16'h0000;
                    end
                    if (imem_ack) begin
                        pc_d    = redir_pc_q;
                        state_d = C_FETCH;
                    end
                end
            end

            default: begin
                state_d = C_IDLE;
            end
        endcase
    end

    // State, PC and pipeline register update with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= C_IDLE;
            pc_q          <= RESET_PC;
            redir_pc_q    <= 16'h0000;
            skid_instr_q  <= 16'h0000;
            skid_pc_q     <= 16'h0000;
            if_id_valid_q <= 1'b0;
            if_id_instr_q <= C_NOP_INSTR;
            if_id_pc_q    <= 16'h0000;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            redir_pc_q    <= redir_pc_d;
            skid_instr_q  <= skid_instr_d;
            skid_pc_q     <= skid_pc_d;
            if_id_valid_q <= if_id_valid_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc_q    <= if_id_pc_d;
        end
    end

`ifdef FETCH_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt_q, bubble_cnt_d;

    // Count each out-of-reset cycle in which IF/ID holds a bubble, saturating
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (!if_id_valid_q && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    // Bubble counter register, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bubble_cnt_q <= 16'h0000;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Directed self-checking bench for fetch_stage. Delivered
//                instructions are checked through a scoreboard queue;
//                bubbles, memory-side outputs and the optional bubble counter
//                (FETCH_BUBBLE_CNT_EN) are checked directly. A second instance
//                with RESET_PC = 16'hFFFF covers PC wrap-around.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        if_id_valid;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc;

    // Second instance: wrap-around reset PC, zero-wait memory
    logic        req2;
    logic [15:0] addr2;
    logic        ack2;
    logic [15:0] rdata2;
    logic        valid2;
    logic [15:0] instr2;
    logic [15:0] pc2;

`ifdef FETCH_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt;
    logic [15:0] bubble_cnt2;
`endif

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
        int          due;
    } sb_entry_t;

    sb_entry_t sb[$];
    int        cyc;
    int        vectors;
    int        miscompares;

    fetch_stage #(.RESET_PC(16'h0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .if_id_valid   (if_id_valid),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc)
`ifdef FETCH_BUBBLE_CNT_EN
        ,
        .bubble_cnt    (bubble_cnt)
`endif
    );

    fetch_stage #(.RESET_PC(16'hFFFF)) dut_wrap (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (req2),
        .imem_addr     (addr2),
        .imem_ack      (ack2),
        .imem_rdata    (rdata2),
        .stall         (1'b0),
        .branch_taken  (1'b0),
        .branch_target (16'h0000),
        .if_id_valid   (valid2),
        .if_id_instr   (instr2),
        .if_id_pc      (pc2)
`ifdef FETCH_BUBBLE_CNT_EN
        ,
        .bubble_cnt    (bubble_cnt2)
`endif
    );

    // Zero-wait memory for the wrap-around instance
    assign ack2   = req2;
    assign rdata2 = {4'h0, addr2[11:0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] instr, input logic [15:0] pc);
        sb_entry_t e;
        e.instr = instr;
        e.pc    = pc;
        e.due   = cyc + 1;
        sb.push_back(e);
    endtask

    // Advance one clock, sample 1 time unit after the edge, retire due entries
    task automatic tick();
        sb_entry_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("sb_valid", 16'(if_id_valid), 16'd1);
            check("sb_instr", if_id_instr, e.instr);
            check("sb_pc",    if_id_pc,    e.pc);
        end
    endtask

    // Zero-wait memory response for the next edge; records the delivery it implies
    task automatic drive_zw();
        imem_ack   = imem_req;
        imem_rdata = {4'h0, imem_addr[11:0]};
        if (imem_req && !stall && !branch_taken) begin
            push({4'h0, imem_addr[11:0]}, imem_addr + 16'd1);
        end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        cyc           = 0;
        rst_n         = 1'b0;
        imem_ack      = 1'b0;
        imem_rdata    = 16'h0000;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 16'h0000;

        // ---------------- reset state
        tick();
        tick();
        check("rst_req",   16'(imem_req),    16'd0);
        check("rst_addr",  imem_addr,        16'h0000);
        check("rst_valid", 16'(if_id_valid), 16'd0);
        check("rst_instr", if_id_instr,      16'h0000);
        check("rst_pc",    if_id_pc,         16'h0000);
        check("rst_addr2", addr2,            16'hFFFF);
`ifdef FETCH_BUBBLE_CNT_EN
        check("rst_bcnt",  bubble_cnt,       16'h0000);
`endif

        // ---------------- release: first request in the second cycle
        rst_n = 1'b1;
        tick();
        check("rel_req",   16'(imem_req), 16'd1);
        check("rel_addr",  imem_addr,     16'h0000);
        check("rel_addr2", addr2,         16'hFFFF);

        // ---------------- zero-wait streaming, one instruction per cycle
        for (int k = 0; k < 6; k++) begin
            check("zw_addr", imem_addr, 16'(k));
            drive_zw();
            tick();
            if (k == 0) begin
                check("wrap_valid", 16'(valid2), 16'd1);
                check("wrap_instr", instr2,      16'h0FFF);
                check("wrap_pc",    pc2,         16'h0000);
                check("wrap_addr",  addr2,       16'h0000);
`ifdef FETCH_BUBBLE_CNT_EN
                check("bcnt_first",  bubble_cnt,  16'd2);
                check("bcnt2_first", bubble_cnt2, 16'd2);
`endif
            end
        end
        imem_ack = 1'b0;

        // ---------------- two-cycle memory latency: valid pattern 0,0,1
        for (int i = 0; i < 3; i++) begin
            check("lat_addr", imem_addr, 16'(6 + i));
            tick();
            check("lat_v0", 16'(if_id_valid), 16'd0);
            tick();
            check("lat_v1", 16'(if_id_valid), 16'd0);
            check("lat_hold_addr", imem_addr, 16'(6 + i));
            imem_ack   = 1'b1;
            imem_rdata = {4'h3, imem_addr[11:0]};
            push({4'h3, imem_addr[11:0]}, imem_addr + 16'd1);
            tick();
            imem_ack = 1'b0;
        end

        // ---------------- stall across an ack: skid then release
        imem_ack   = 1'b1;
        imem_rdata = 16'h1111;
        push(16'h1111, 16'd10);
        tick();
        stall      = 1'b1;
        imem_rdata = 16'h5123;
        tick();
        imem_ack = 1'b0;
        for (int s = 0; s < 3; s++) begin
            check("stall_req",   16'(imem_req),    16'd0);
            check("stall_valid", 16'(if_id_valid), 16'd1);
            check("stall_instr", if_id_instr,      16'h1111);
            check("stall_pc",    if_id_pc,         16'd10);
            if (s < 2) tick();
        end
        stall = 1'b0;
        push(16'h5123, 16'd11);
        tick();
        check("unstall_req",  16'(imem_req), 16'd1);
        check("unstall_addr", imem_addr,     16'd11);

        // ---------------- branch while request pending, late wrong-path ack
        branch_taken  = 1'b1;
        branch_target = 16'h0040;
        tick();
        branch_taken = 1'b0;
        check("drop_valid", 16'(if_id_valid), 16'd0);
        check("drop_instr", if_id_instr,      16'h0000);
        check("drop_req",   16'(imem_req),    16'd1);
        check("drop_addr",  imem_addr,        16'd11);
        imem_ack   = 1'b1;
        imem_rdata = 16'hFFFF;
        tick();
        imem_ack = 1'b0;
        check("drop_ack_valid", 16'(if_id_valid), 16'd0);
        check("drop_ack_instr", if_id_instr,      16'h0000);
        check("redir_addr",     imem_addr,        16'h0040);
        drive_zw();
        tick();

        // ---------------- zero-wait branch: one bubble, target two cycles later
        imem_ack      = 1'b1;
        imem_rdata    = 16'h0041;
        branch_taken  = 1'b1;
        branch_target = 16'h0100;
        tick();
        branch_taken = 1'b0;
        check("zwbr_valid", 16'(if_id_valid), 16'd0);
        check("zwbr_addr",  imem_addr,        16'h0100);
        drive_zw();
        tick();

        // ---------------- branch and stall together in HOLD
        stall      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 16'h7777;
        tick();
        imem_ack = 1'b0;
        check("hold_req",   16'(imem_req), 16'd0);
        check("hold_instr", if_id_instr,   16'h0100);
        branch_taken  = 1'b1;
        branch_target = 16'h0200;
        tick();
        branch_taken = 1'b0;
        stall        = 1'b0;
        check("holdbr_valid", 16'(if_id_valid), 16'd0);
        check("holdbr_instr", if_id_instr,      16'h0000);
        check("holdbr_req",   16'(imem_req),    16'd1);
        check("holdbr_addr",  imem_addr,        16'h0200);
        drive_zw();
        tick();
        imem_ack = 1'b0;

        // ---------------- two redirects during DROP: latest wins
        branch_taken  = 1'b1;
        branch_target = 16'h0300;
        tick();
        branch_target = 16'h0310;
        tick();
        branch_taken = 1'b0;
        check("drop2_req",  16'(imem_req), 16'd1);
        check("drop2_addr", imem_addr,     16'h0201);
        imem_ack   = 1'b1;
        imem_rdata = 16'hFFFF;
        tick();
        imem_ack = 1'b0;
        check("latest_addr",  imem_addr,        16'h0310);
        check("latest_valid", 16'(if_id_valid), 16'd0);
        drive_zw();
        tick();
        imem_ack = 1'b0;
        tick();

        check("sb_drain", 16'(sb.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
